pcpu_pipe_ctrl: RTL and testbench

//  Parametrised pipeline sequencer for the PCPU family; successor to the fixed 5-stage CPU_Control.

---
 rtl/pcpu_pipe_ctrl_if.sv | 46 ++++
 rtl/pcpu_pipe_ctrl.sv | 144 ++++++++++++++
 tb/tb_pcpu_pipe_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcpu_pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// pcpu_pipe_ctrl_if
// Purpose : groups the hazard inputs and the control/status outputs of the
//           PCPU pipeline sequencer so they can be passed as a single port.
// Modports:
//   master - driven by the datapath / environment: enable, start, ID source
//            registers and use flags, EX load/destination, br_taken,
//            mem_wait, wb_halt. Observes state, stage_en, stage_valid,
//            pc_en, retired, stall_cycles.
//   slave  - the sequencer itself (pcpu_pipe_ctrl), the reverse direction.
// -----------------------------------------------------------------------------
interface pcpu_pipe_ctrl_if #(
   parameter int unsigned STAGES = 5,
   parameter int unsigned RA_W   = 3,
   parameter int unsigned CNT_W  = 16
);
   logic              enable;
   logic              start;
   logic [RA_W-1:0]   id_rs_a;
   logic [RA_W-1:0]   id_rs_b;
   logic              id_use_a;
   logic              id_use_b;
   logic              ex_is_load;
   logic [RA_W-1:0]   ex_rd;
   logic              br_taken;
   logic              mem_wait;
   logic              wb_halt;
   logic [1:0]        state;
   logic [STAGES-1:0] stage_en;
   logic [STAGES-1:0] stage_valid;
   logic              pc_en;
   logic [CNT_W-1:0]  retired;
   logic [CNT_W-1:0]  stall_cycles;

   modport master (
      output enable, start, id_rs_a, id_rs_b, id_use_a, id_use_b,
             ex_is_load, ex_rd, br_taken, mem_wait, wb_halt,
      input  state, stage_en, stage_valid, pc_en, retired, stall_cycles
   );

   modport slave (
      input  enable, start, id_rs_a, id_rs_b, id_use_a, id_use_b,
             ex_is_load, ex_rd, br_taken, mem_wait, wb_halt,
      output state, stage_en, stage_valid, pc_en, retired, stall_cycles
   );
endinterface

// File: rtl/pcpu_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pcpu_pipe_ctrl
// Purpose : run-state machine (IDLE/RUN/HALT) and per-stage valid/enable
//           sequencing for a STAGES-deep PCPU pipeline. Handles load-use
//           stall, taken-branch flush, data-memory wait freeze and halt.
//           Stage 0 = IF, 1 = ID, 2 = EX, ..., STAGES-1 = WB.
// Ports   :
//   clock  in  rising-edge clock
//   reset  in  synchronous, active-high
//   bus    pcpu_pipe_ctrl_if.slave - hazard inputs, state/stage_en/
//          stage_valid/pc_en outputs and the retired/stall_cycles counters
// Config  : define PCPU_PERF_CNT_EN to build the saturating retired and
//           stall_cycles counters; otherwise both read 0 and no counter
//           flops exist.
// -----------------------------------------------------------------------------
module pcpu_pipe_ctrl #(
   parameter int unsigned STAGES   = 5,
   parameter int unsigned RA_W     = 3,
   parameter int unsigned BR_STAGE = 3,
   parameter int unsigned CNT_W    = 16
) (
   input logic              clock,
   input logic              reset,
   pcpu_pipe_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_HALT = 2'b10
   } state_t;

   // Stages 0..BR_STAGE are squashed by a taken branch.
   localparam logic [STAGES-1:0] BR_FLUSH_MASK = {STAGES{1'b1}} >> (STAGES - BR_STAGE - 1);

   state_t            r_state;
   logic [STAGES-1:0] r_valid;

   logic [RA_W-1:0]   w_ex_rd;
   logic              w_run;
   logic              w_halt;
   logic              w_br;
   logic              w_lu;
   logic              w_retire;
   logic              w_stall;
   logic              w_pc_en;
   logic [STAGES-1:0] w_stage_en;
   logic [STAGES-1:0] w_shift;
   logic [STAGES-1:0] w_valid_nxt;

   assign w_ex_rd = bus.ex_rd;

   always_comb begin
      w_run   = (r_state == ST_RUN) && bus.enable;
      w_halt  = bus.wb_halt && r_valid[STAGES-1];
      w_br    = bus.br_taken && r_valid[BR_STAGE];
      w_lu    = bus.ex_is_load && r_valid[2] && r_valid[1] &&
                ((bus.id_use_a && (bus.id_rs_a == w_ex_rd)) ||
                 (bus.id_use_b && (bus.id_rs_b == w_ex_rd)));
      w_shift = {r_valid[STAGES-2:0], 1'b0};

      w_stage_en  = '0;
      w_pc_en     = 1'b0;
      w_valid_nxt = r_valid;
      w_retire    = 1'b0;
      w_stall     = 1'b0;

      // Priority: halt > mem_wait freeze > branch flush > load-use > advance.
      if (w_run) begin
         if (w_halt) begin
            w_valid_nxt = '0;
            w_retire    = 1'b1;
         end else if (bus.mem_wait) begin
            w_stall = 1'b1;
         end else if (w_br) begin
            w_stage_en  = '1;
            w_pc_en     = 1'b1;
            w_retire    = r_valid[STAGES-1];
            w_valid_nxt = w_shift & ~BR_FLUSH_MASK;
         end else if (w_lu) begin
            // IF/ID hold their instructions; a bubble enters EX.
            w_stage_en  = {{(STAGES-2){1'b1}}, 2'b00};
            w_retire    = r_valid[STAGES-1];
            w_stall     = 1'b1;
            w_valid_nxt = {w_shift[STAGES-1:3], 1'b0, r_valid[1:0]};
         end else begin
            w_stage_en  = '1;
            w_pc_en     = 1'b1;
            w_retire    = r_valid[STAGES-1];
            w_valid_nxt = w_shift | {{(STAGES-1){1'b0}}, 1'b1};
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_valid <= '0;
      end else if (bus.enable) begin
         case (r_state)
            ST_RUN: begin
               r_valid <= w_valid_nxt;
               if (w_halt) r_state <= ST_HALT;
            end
            default: begin
               if (bus.start) begin
                  r_state <= ST_RUN;
                  r_valid <= '0;
               end
            end
         endcase
      end
   end

   assign bus.state       = r_state;
   assign bus.stage_valid = r_valid;
   assign bus.stage_en    = w_stage_en;
   assign bus.pc_en       = w_pc_en;

`ifdef PCPU_PERF_CNT_EN
   logic [CNT_W-1:0] r_retired;
   logic [CNT_W-1:0] r_stall_cycles;

   // Both counters stick at all-ones instead of wrapping.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_retired      <= '0;
         r_stall_cycles <= '0;
      end else begin
         if (w_retire && (r_retired != '1))     r_retired      <= r_retired + 1'b1;
         if (w_stall && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 1'b1;
      end
   end

   assign bus.retired      = r_retired;
   assign bus.stall_cycles = r_stall_cycles;
`else
   logic w_unused_cnt;
   assign w_unused_cnt     = w_retire ^ w_stall;
   assign bus.retired      = {CNT_W{1'b0}};
   assign bus.stall_cycles = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pcpu_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pcpu_pipe_ctrl
// Purpose : scoreboard bench for pcpu_pipe_ctrl. A stimulus process drives one
//           input vector per cycle, predicts the outputs from a token-level
//           model of the pipeline (each stage holds an instruction number or
//           is empty) and queues the prediction; a monitor pops and compares
//           on the falling edge.
// -----------------------------------------------------------------------------
module tb_pcpu_pipe_ctrl;

   localparam int S  = 5;
   localparam int RA = 3;
   localparam int BR = 3;
   localparam int CW = 16;
   localparam int CMAX = (1 << CW) - 1;

   typedef struct {
      logic rst, en, st, ua, ub, ld, br, mw, wh;
      logic [RA-1:0] rsa, rsb, rd;
   } stim_t;

   typedef struct {
      logic [1:0]    state;
      logic [S-1:0]  valid;
      logic [S-1:0]  en;
      logic          pc;
      logic [CW-1:0] ret;
      logic [CW-1:0] stl;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   pcpu_pipe_ctrl_if #(.STAGES(S), .RA_W(RA), .CNT_W(CW)) bus ();

   pcpu_pipe_ctrl #(.STAGES(S), .RA_W(RA), .BR_STAGE(BR), .CNT_W(CW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   exp_t q[$];
   int   n_pass  = 0;
   int   n_total = 0;

   // Reference model: mode 0 idle, 1 run, 2 halt; m_tok[i] = instruction
   // number occupying stage i, -1 when empty.
   int m_mode = 0;
   int m_tok[S];
   int m_seq  = 0;
   int m_ret  = 0;
   int m_stl  = 0;

   function automatic int sat(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   function automatic logic [S-1:0] tok_valid();
      logic [S-1:0] v;
      for (int i = 0; i < S; i++) v[i] = (m_tok[i] >= 0);
      return v;
   endfunction

   function automatic stim_t nop();
      stim_t s;
      s = '{rst: 1'b0, en: 1'b1, st: 1'b0, ua: 1'b0, ub: 1'b0, ld: 1'b0,
            br: 1'b0, mw: 1'b0, wh: 1'b0, rsa: '0, rsb: '0, rd: '0};
      return s;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic step(input stim_t s);
      exp_t e;
      bit   busy, halt_hit, br_hit, lu_hit;
      @(posedge clock);
      #2;
      reset           = s.rst;
      bus.enable      = s.en;
      bus.start       = s.st;
      bus.id_use_a    = s.ua;
      bus.id_use_b    = s.ub;
      bus.id_rs_a     = s.rsa;
      bus.id_rs_b     = s.rsb;
      bus.ex_is_load  = s.ld;
      bus.ex_rd       = s.rd;
      bus.br_taken    = s.br;
      bus.mem_wait    = s.mw;
      bus.wb_halt     = s.wh;

      e.state = 2'(m_mode);
      e.valid = tok_valid();
`ifdef PCPU_PERF_CNT_EN
      e.ret = CW'(m_ret);
      e.stl = CW'(m_stl);
`else
      e.ret = '0;
      e.stl = '0;
`endif
      busy     = (m_mode == 1) && s.en;
      halt_hit = s.wh && (m_tok[S-1] >= 0);
      br_hit   = s.br && (m_tok[BR] >= 0);
      lu_hit   = s.ld && (m_tok[2] >= 0) && (m_tok[1] >= 0) &&
                 ((s.ua && s.rsa == s.rd) || (s.ub && s.rsb == s.rd));
      e.en = '0;
      e.pc = 1'b0;
      if (busy && !halt_hit && !s.mw) begin
         e.en = '1;
         if (br_hit || !lu_hit) e.pc = 1'b1;
         else begin
            e.en[0] = 1'b0;
            e.en[1] = 1'b0;
         end
      end
      q.push_back(e);

      // Effect of the coming clock edge.
      if (s.rst) begin
         m_mode = 0;
         foreach (m_tok[i]) m_tok[i] = -1;
         m_ret = 0;
         m_stl = 0;
      end else if (!s.en) begin
         // frozen
      end else if (m_mode != 1) begin
         if (s.st) begin
            m_mode = 1;
            foreach (m_tok[i]) m_tok[i] = -1;
         end
      end else if (halt_hit) begin
         m_ret  = sat(m_ret + 1);
         m_mode = 2;
         foreach (m_tok[i]) m_tok[i] = -1;
      end else if (s.mw) begin
         m_stl = sat(m_stl + 1);
      end else begin
         if (m_tok[S-1] >= 0) m_ret = sat(m_ret + 1);
         if (br_hit) begin
            for (int i = S - 1; i >= 1; i--) m_tok[i] = (i > BR) ? m_tok[i-1] : -1;
            m_tok[0] = -1;
         end else if (lu_hit) begin
            for (int i = S - 1; i >= 3; i--) m_tok[i] = m_tok[i-1];
            m_tok[2] = -1;
            m_stl = sat(m_stl + 1);
         end else begin
            for (int i = S - 1; i >= 1; i--) m_tok[i] = m_tok[i-1];
            m_tok[0] = m_seq;
            m_seq++;
         end
      end
   endtask

   task automatic repeat_nop(input int n);
      for (int k = 0; k < n; k++) step(nop());
   endtask

   // Monitor: one comparison set per queued prediction.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("state",        32'(bus.state),        32'(e.state));
            chk("stage_valid",  32'(bus.stage_valid),  32'(e.valid));
            chk("stage_en",     32'(bus.stage_en),     32'(e.en));
            chk("pc_en",        32'(bus.pc_en),        32'(e.pc));
            chk("retired",      32'(bus.retired),      32'(e.ret));
            chk("stall_cycles", 32'(bus.stall_cycles), 32'(e.stl));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      stim_t s;
      foreach (m_tok[i]) m_tok[i] = -1;
      bus.enable = 1'b1; bus.start = 1'b0;
      bus.id_use_a = 1'b0; bus.id_use_b = 1'b0;
      bus.id_rs_a = '0; bus.id_rs_b = '0;
      bus.ex_is_load = 1'b0; bus.ex_rd = '0;
      bus.br_taken = 1'b0; bus.mem_wait = 1'b0; bus.wb_halt = 1'b0;

      // Reset held two cycles, then idle without start.
      s = nop(); s.rst = 1'b1;
      step(s); step(s);
      repeat_nop(2);

      // Start, then a hazard-free run.
      s = nop(); s.st = 1'b1; step(s);
      repeat_nop(8);

      // Load-use on rs_a.
      s = nop(); s.ld = 1'b1; s.rd = 3'd3; s.ua = 1'b1; s.rsa = 3'd3; step(s);
      // Load-use on rs_b, and a non-matching load.
      s = nop(); s.ld = 1'b1; s.rd = 3'd5; s.ub = 1'b1; s.rsb = 3'd5; step(s);
      s = nop(); s.ld = 1'b1; s.rd = 3'd5; s.ua = 1'b1; s.rsa = 3'd4; step(s);
      repeat_nop(4);

      // Taken branch with a full pipe.
      s = nop(); s.br = 1'b1; step(s);
      repeat_nop(5);

      // mem_wait with pending branch, then branch alone.
      s = nop(); s.br = 1'b1; s.mw = 1'b1;
      step(s); step(s); step(s);
      s.mw = 1'b0; step(s);
      repeat_nop(5);

      // Branch together with load-use: branch wins.
      s = nop(); s.br = 1'b1; s.ld = 1'b1; s.rd = 3'd2; s.ua = 1'b1; s.rsa = 3'd2; step(s);
      repeat_nop(5);

      // enable low freezes everything.
      s = nop(); s.en = 1'b0; s.br = 1'b1; s.st = 1'b1; step(s); step(s);
      repeat_nop(5);

      // Halt, restart, reset mid-run.
      s = nop(); s.wh = 1'b1; step(s);
      repeat_nop(2);
      s = nop(); s.st = 1'b1; step(s);
      repeat_nop(3);
      s = nop(); s.rst = 1'b1; step(s);
      repeat_nop(2);

      // Randomized phase.
      for (int k = 0; k < 600; k++) begin
         s     = nop();
         s.rst = ($urandom_range(0, 59) == 0);
         s.en  = ($urandom_range(0, 7) != 0);
         s.st  = ($urandom_range(0, 5) == 0);
         s.br  = ($urandom_range(0, 5) == 0);
         s.mw  = ($urandom_range(0, 7) == 0);
         s.wh  = ($urandom_range(0, 24) == 0);
         s.ld  = ($urandom_range(0, 2) == 0);
         s.ua  = $urandom_range(0, 1);
         s.ub  = $urandom_range(0, 1);
         s.rd  = RA'($urandom);
         s.rsa = $urandom_range(0, 1) ? s.rd : RA'($urandom);
         s.rsb = $urandom_range(0, 1) ? s.rd : RA'($urandom);
         step(s);
      end

      @(negedge clock);
      #1;
      if (q.size() != 0) begin
         n_total++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
